// File: rtl/pcecd_cmd_if.sv
// Command-byte stream in, assembled CDB out.
// master drives bytes and accepts CDBs; slave is the assembler.
interface pcecd_cmd_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  opcode;
  logic [3:0]  cmd_len;
  logic [95:0] cmd_bytes;
  logic        cmd_error;
  logic        timeout;
  logic        busy;

  modport master (
    output byte_valid, byte_data, abort, cmd_ready,
    input  byte_ready, cmd_valid, opcode, cmd_len,
    input  cmd_bytes, cmd_error, timeout, busy
  );

  modport slave (
    input  byte_valid, byte_data, abort, cmd_ready,
    output byte_ready, cmd_valid, opcode, cmd_len,
    output cmd_bytes, cmd_error, timeout, busy
  );
endinterface

// File: rtl/pcecd_cmd_assembler.sv
// Assembles SCSI/NEC CDBs from PHASE_COMMAND bytes.
// Length from opcode group; reserved groups and stalls flagged.
module pcecd_cmd_assembler #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic        i_clk,
  input logic        i_rst_n,
  pcecd_cmd_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PRESENT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    op_q, op_d;
  logic [3:0]    len_q, len_d;
  logic [95:0]   cdb_q, cdb_d;
  logic          err_q, err_d;
  logic          to_q, to_d;
  logic          busy_q;
  logic [3:0]    grp_len;

  // 0 marks a reserved opcode group
  always_comb begin
    grp_len = 4'd0;
    unique case (bus.byte_data[7:5])
      3'd0: grp_len = 4'd6;
      3'd1: grp_len = 4'd10;
      3'd2: grp_len = 4'd10;
      3'd3: grp_len = 4'd0;
      3'd4: grp_len = 4'd0;
      3'd5: grp_len = 4'd12;
      3'd6: grp_len = 4'd10;
      3'd7: grp_len = 4'd10;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    len_d   = len_q;
    cdb_d   = cdb_q;
    err_d   = err_q;
    to_d    = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      err_d   = 1'b0;
      idx_d   = 4'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.byte_valid) begin
            cdb_d = {88'd0, bus.byte_data};
            op_d  = bus.byte_data;
            if (grp_len == 4'd0) begin
              len_d   = 4'd1;
              err_d   = 1'b1;
              state_d = PRESENT;
            end else begin
              len_d   = grp_len;
              idx_d   = 4'd1;
              cnt_d   = '0;
              state_d = COLLECT;
            end
          end
        end
        COLLECT: begin
          if (bus.byte_valid) begin
            cdb_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
            cnt_d = '0;
            if (idx_q == len_q - 4'd1) begin
              idx_d   = 4'd0;
              state_d = PRESENT;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else if (cnt_q == CNT_LAST) begin
            to_d    = 1'b1;
            cdb_d   = '0;
            op_d    = '0;
            len_d   = '0;
            idx_d   = 4'd0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESENT: begin
          if (bus.cmd_ready) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      cdb_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cdb_q   <= cdb_d;
      err_q   <= err_d;
      to_q    <= to_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.byte_ready = (state_q != PRESENT);
  assign bus.cmd_valid  = (state_q == PRESENT);
  assign bus.opcode     = op_q;
  assign bus.cmd_len    = len_q;
  assign bus.cmd_bytes  = cdb_q;
  assign bus.cmd_error  = err_q;
  assign bus.timeout    = to_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pcecd_cmd_assembler.sv
// Random and directed stimulus against a queue-based CDB model.
// Outputs sampled #1 after each rising edge.
module tb_pcecd_cmd_assembler;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcecd_cmd_if bus ();

  pcecd_cmd_assembler #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: bytes gathered so far, whether a CDB is on offer
  logic [7:0] m_q[$];
  bit m_pres, m_err, m_tp, m_zero;
  int m_need, m_idle;

  function automatic int len_for(logic [7:0] op);
    case (op[7:5])
      3'd0:                   return 6;
      3'd1, 3'd2, 3'd6, 3'd7: return 10;
      3'd5:                   return 12;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [95:0] m_cdb();
    logic [95:0] r = '0;
    for (int i = 0; i < m_q.size(); i++) r[8*i +: 8] = m_q[i];
    return r;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_pres = 0; m_err = 0; m_tp = 0; m_zero = 1;
    m_need = 0; m_idle = 0;
  endtask

  task automatic check_outputs();
    chk("ready", bus.byte_ready, !m_pres);
    chk("valid", bus.cmd_valid, m_pres);
    chk("busy", bus.busy, m_pres || m_q.size() != 0);
    chk("timeout", bus.timeout, m_tp);
    if (m_pres) begin
      chk("opcode", bus.opcode, m_q[0]);
      chk("len", bus.cmd_len, m_err ? 1 : m_need);
      chk("cdb", bus.cmd_bytes, m_cdb());
      chk("error", bus.cmd_error, m_err);
    end else begin
      chk("error_idle", bus.cmd_error, 0);
    end
    if (m_zero) begin
      chk("zero_op", bus.opcode, 0);
      chk("zero_len", bus.cmd_len, 0);
      chk("zero_cdb", bus.cmd_bytes, 0);
    end
  endtask

  task automatic cyc(bit bv, logic [7:0] b, bit ab, bit cr);
    bit tp = 0;
    bus.byte_valid = bv;
    bus.byte_data  = b;
    bus.abort      = ab;
    bus.cmd_ready  = cr;
    check_outputs();
    if (ab) begin
      m_pres = 0; m_err = 0; m_q.delete(); m_idle = 0;
    end else if (m_pres) begin
      if (cr) begin
        m_pres = 0; m_err = 0; m_q.delete();
      end
    end else if (bv) begin
      m_q.push_back(b);
      m_zero = 0;
      m_idle = 0;
      if (m_q.size() == 1) begin
        m_need = len_for(b);
        if (m_need == 0) begin
          m_err = 1; m_pres = 1;
        end
      end else if (m_q.size() == m_need) begin
        m_pres = 1;
      end
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == T) begin
        tp = 1; m_q.delete(); m_idle = 0; m_zero = 1;
      end
    end
    m_tp = tp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  initial begin
    bus.byte_valid = 0;
    bus.byte_data  = 0;
    bus.abort      = 0;
    bus.cmd_ready  = 0;
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.cmd_valid, 0);
    chk("rst_ready", bus.byte_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_cdb", bus.cmd_bytes, 0);
    chk("rst_len", bus.cmd_len, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // reset landing mid-collect clears at once
    cyc(1, 8'h28, 0, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    rst_n = 0;
    #2;
    chk("t1_valid", bus.cmd_valid, 0);
    chk("t1_ready", bus.byte_ready, 1);
    chk("t1_cdb", bus.cmd_bytes, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
    idle(2);

    // minimum 6-byte command
    for (int i = 0; i < 6; i++) cyc(1, 8'h00, 0, 0);
    chk("t2_valid", bus.cmd_valid, 1);
    chk("t2_len", bus.cmd_len, 6);
    cyc(0, 8'h00, 0, 1);
    idle(1);

    // NEC vendor opcode held under back-pressure
    begin
      logic [7:0] d3[10] = '{8'hD8, 0, 0, 0, 8'h02, 0, 0, 0, 0, 0};
      for (int i = 0; i < 10; i++) cyc(1, d3[i], 0, 0);
    end
    chk("t3_len", bus.cmd_len, 10);
    for (int i = 0; i < 5; i++) cyc(1, 8'hFF, 0, 0);
    cyc(0, 8'h00, 0, 1);
    chk("t3_ready", bus.byte_ready, 1);
    idle(1);

    // reserved group, then a 12-byte command
    cyc(1, 8'h60, 0, 0);
    chk("t4_err", bus.cmd_error, 1);
    chk("t4_len", bus.cmd_len, 1);
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'hA8, 0, 0);
    for (int i = 1; i < 12; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    chk("t4_len12", bus.cmd_len, 12);
    cyc(0, 8'h00, 0, 1);

    // inter-byte timeout, then normal recovery
    cyc(1, 8'h08, 0, 0);
    idle(T + 4);
    for (int i = 0; i < 6; i++) cyc(1, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 1);

    // abort mid-collect, abort with byte in idle, abort beats ready
    cyc(1, 8'h28, 0, 0);
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(0, 8'h00, 1, 0);
    idle(2);
    cyc(1, 8'h12, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 8'(i + 3), 0, 0);
    cyc(0, 8'h00, 1, 1);
    chk("t6_valid", bus.cmd_valid, 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      bit bv = ($urandom % 10) < 7;
      bit ab = ($urandom % 60) == 0;
      bit cr = ($urandom % 3) != 0;
      cyc(bv, 8'($urandom), ab, cr);
      if ($urandom % 150 == 0) idle(T + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
